// File: rtl/vga_timing_if.sv
// vga_timing_if: raster timing bundle produced by vga_timing_gen and
// consumed by the pixel-producing stages (background renderer, sprites).
// master = the timing generator, slave = any consumer of the raster.
interface vga_timing_if;
  logic [9:0]  DrawX;
  logic [9:0]  DrawY;
  logic        blank;
  logic        hs;
  logic        vs;
  logic        line_start;
  logic        frame_start;
  logic [15:0] frame_count;

  modport master (
    output DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );

  modport slave (
    input  DrawX, DrawY, blank, hs, vs, line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// vga_timing_gen: free-running 640x480@60 raster timing generator.
// DrawX/DrawY/blank come straight from the counter registers; hs/vs are
// delayed by SYNC_DELAY stages so they line up with the registered colour
// output of downstream pixel stages.
// Optional feature macro: VGA_FRAME_COUNTER_EN builds the 16-bit
// frame_count register; without it frame_count is tied to zero.
module vga_timing_gen #(
  parameter int H_VISIBLE  = 640,
  parameter int H_FRONT    = 16,
  parameter int H_SYNC     = 96,
  parameter int H_BACK     = 48,
  parameter int V_VISIBLE  = 480,
  parameter int V_FRONT    = 10,
  parameter int V_SYNC     = 2,
  parameter int V_BACK     = 33,
  parameter int SYNC_DELAY = 1    // 0..4 stages on hs/vs only
) (
  input  logic         vga_clk,
  input  logic         reset_n,
  vga_timing_if.master vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Sized copies of the raster boundaries so every compare is 10 bits wide.
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_ACTIVE = 10'(H_VISIBLE);
  localparam logic [9:0] V_ACTIVE = 10'(V_VISIBLE);
  localparam logic [9:0] HS_FIRST = 10'(H_VISIBLE + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_VISIBLE + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_VISIBLE + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_VISIBLE + V_FRONT + V_SYNC - 1);

  logic [9:0] hc;
  logic [9:0] vc;
  logic       h_wrap;
  logic       v_wrap;
  logic       frame_wrap;
  logic       hsync_raw;
  logic       vsync_raw;
  logic       line_start_q;
  logic       frame_start_q;

  // Wrap conditions: end of line, and end of line on the last line.
  assign h_wrap     = (hc == H_LAST);
  assign v_wrap     = (vc == V_LAST);
  assign frame_wrap = h_wrap && v_wrap;

  // Horizontal and vertical raster counters; vc advances only on the hc wrap.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      hc <= '0;
      vc <= '0;
    end else begin
      // NOTE: state registers use non-blocking assignment so every flop
      // samples the pre-edge values; blocking here would let vc see the
      // already-wrapped hc and skew the two counters.
      hc <= h_wrap ? '0 : hc + 10'd1;
      if (h_wrap) begin
        vc <= v_wrap ? '0 : vc + 10'd1;
      end
    end
  end

  // Start-of-line / start-of-frame pulses, set on the edge the counters
  // load their wrap values so they align with DrawX == 0 and (0, 0).
  // Reset leaves them low, so line 0 and frame 1 after reset get no pulse.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
    end else begin
      line_start_q  <= h_wrap;
      frame_start_q <= frame_wrap;
    end
  end

  // Raw active-low syncs decoded from the undelayed counters.
  // NOTE: pure continuous decodes of registers; no process with a missing
  // branch exists here, so nothing can be inferred as a latch.
  assign hsync_raw = !((hc >= HS_FIRST) && (hc <= HS_LAST));
  assign vsync_raw = !((vc >= VS_FIRST) && (vc <= VS_LAST));

  // Sync delay chain: aligns hs/vs with one or more registered pixel stages.
  generate
    if (SYNC_DELAY == 0) begin : g_sync_comb
      assign vga.hs = hsync_raw;
      assign vga.vs = vsync_raw;
    end else begin : g_sync_delay
      logic [SYNC_DELAY-1:0] hs_pipe;
      logic [SYNC_DELAY-1:0] vs_pipe;

      // Shift raw syncs through SYNC_DELAY flops, oldest at the top index.
      always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
          // NOTE: every stage is reset (to the inactive level 1), not just
          // the output; a stale low left in the chain would emit a partial
          // sync pulse right after a mid-frame reset is released.
          hs_pipe <= '1;
          vs_pipe <= '1;
        end else begin
          hs_pipe[0] <= hsync_raw;
          vs_pipe[0] <= vsync_raw;
          for (int i = 1; i < SYNC_DELAY; i++) begin
            hs_pipe[i] <= hs_pipe[i-1];
            vs_pipe[i] <= vs_pipe[i-1];
          end
        end
      end

      assign vga.hs = hs_pipe[SYNC_DELAY-1];
      assign vga.vs = vs_pipe[SYNC_DELAY-1];
    end
  endgenerate

`ifdef VGA_FRAME_COUNTER_EN
  logic [15:0] frame_count_q;

  // Completed-frame counter; steps on the same edge as frame_start rises.
  always_ff @(posedge vga_clk or negedge reset_n) begin
    if (!reset_n) begin
      frame_count_q <= '0;
    end else if (frame_wrap) begin
      frame_count_q <= frame_count_q + 16'd1;
    end
  end

  assign vga.frame_count = frame_count_q;
`else
  // Frame counter not built; consumers see a constant zero timebase.
  assign vga.frame_count = 16'h0000;
`endif

  // Coordinates and active-video qualifier, cycle-aligned with the counters.
  assign vga.DrawX       = hc;
  assign vga.DrawY       = vc;
  assign vga.blank       = (hc < H_ACTIVE) && (vc < V_ACTIVE);
  assign vga.line_start  = line_start_q;
  assign vga.frame_start = frame_start_q;

endmodule
